axis_inject_mux: RTL and testbench
==================================

# axis_inject_mux

Multi-channel NoC injection port: arbitrates NUM_CHANNELS independent AXI-Stream sources onto one router input port using packet-atomic round-robin, flit-level credit flow control, and a registered flit output. It sits between user AXIS producers (already in the NoC clock domain) and the local input of a router. It replaces the single-source serializer shim wherever several producers share one endpoint.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of AXIS sources (≥1).
- TDATA_WIDTH, 64: flit payload width; one AXIS beat is one flit.
- TID_WIDTH, 2: AXIS tid width.
- TDEST_WIDTH, 4: AXIS tdest width.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH: flit destination width.
- FLIT_BUFFER_DEPTH, 8: router input buffer depth; initial credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1): credit counter width.

Ports:
- Clocking: one clock; reset is synchronous and active-low, with the ports named `clk_noc` and `rst_n`.
- clk_noc  in  1  NoC clock.
- rst_n  in  1  synchronous active-low reset.
- axis_in_tvalid  in  [NUM_CHANNELS]  per-channel valid.
- axis_in_tready  out  [NUM_CHANNELS]  per-channel ready (combinational).
- axis_in_tdata  in  [NUM_CHANNELS][TDATA_WIDTH]  payload.
- axis_in_tlast  in  [NUM_CHANNELS]  last beat of packet.
- axis_in_tid  in  [NUM_CHANNELS][TID_WIDTH]  id.
- axis_in_tdest  in  [NUM_CHANNELS][TDEST_WIDTH]  destination.
- data_out  out  TDATA_WIDTH  flit payload.
- dest_out  out  DEST_WIDTH  {tid, tdest} of the flit.
- is_tail_out  out  1  flit is packet tail.
- send_out  out  1  flit valid, one-cycle pulse per flit.
- credit_in  in  1  one credit returned by the router.
- credit_err  out  1  sticky: credit returned while counter full.

## Operation
- FSM states: IDLE, LOCKED(owner).
- IDLE: the round-robin arbiter picks the first channel with tvalid, searching from rr_ptr upward with wrap-around. The pick is combinational, in the same cycle.
- tready[c] = rst_n & (credit_cnt≠0) & (c == owner in LOCKED, or c == pick in IDLE). All other readys are 0.
- A transfer on channel c with tlast=0 → LOCKED(owner=c).
- A transfer with tlast=1, in either state → IDLE, rr_ptr = (c+1) mod NUM_CHANNELS. Single-flit packets never enter LOCKED.
- LOCKED: other channels are stalled even if the owner deasserts tvalid. Packets are never interleaved.
- Credit counter: next = cnt − xfer + credit_in. Simultaneous xfer and credit_in leaves cnt unchanged.
- At cnt=0 no transfer occurs and state is held; a mid-packet stall stays LOCKED.
- credit_in while cnt==FLIT_BUFFER_DEPTH (and no xfer): cnt saturates, credit_err is set and stays set until reset.
- dest_out = {tid, tdest} of every flit, head and body alike.

## Timing
- Latency: AXIS handshake in cycle t → send_out=1 with data_out/dest_out/is_tail_out in cycle t+1.
- When no transfer occurs, send_out=0 and the data fields hold their last value.
- Throughput: one flit per cycle while credits last. Zero-bubble between packets, including a channel switch in the cycle after tlast.
- Credit visibility: credit_in in cycle t → cnt incremented at t+1 → a transfer is possible in t+1.
- Reset values: send_out=0, is_tail_out=0, data_out=0, dest_out=0, credit_err=0, all tready=0 while rst_n=0, state=IDLE, rr_ptr=0, cnt=FLIT_BUFFER_DEPTH.
- Reset mid-packet: the partial packet is abandoned. The whole NoC resets together, so no tail recovery is performed.

## Configuration
- AXIS_INJECT_STATS_EN defined: adds output pkt_count [NUM_CHANNELS][32].
  - Per-channel count of completed packets, i.e. tlast transfers.
  - Increments in the cycle after the transfer, wraps at 2^32, reset to 0.
  - Adds output stall_cycles [32]: cycles with cnt=0 and some tvalid=1, wraps at 2^32, reset to 0.
- AXIS_INJECT_STATS_EN undefined: neither port nor its counters exist. All other behaviour is identical.

## Structure
- Shared package noc_pkg:
  - flit typedef (data, dest, is_tail).
  - inject_state_t enum {IDLE, LOCKED}.
  - credit width helper function.
- Sub-module rr_arbiter: parameter N. Inputs req[N], ptr. Outputs one-hot gnt and index; purely combinational. Reusable by router output allocation.
- The top holds the FSM, owner/rr_ptr registers, credit counter, output register and optional stats.

## Test plan
- Reset then single channel: ch0 sends a 3-flit packet (tdest=5, tid=1) → send_out on 3 consecutive cycles starting 1 cycle after the first handshake, dest_out=0x15, is_tail_out only on the 3rd flit.
- Fairness: all 4 channels hold 2-flit packets continuously → grant order 0,1,2,3,0…, no interleaving, no idle cycle between packets.
- Credit exhaustion: FLIT_BUFFER_DEPTH=8, credit_in held 0, ch1 offers a 12-flit packet → exactly 8 flits sent, tready low, state LOCKED. Then one credit_in pulse → exactly 1 more flit, on the next cycle.
- Simultaneous credit and send at cnt=1 → cnt stays 1, streaming continues uninterrupted. credit_in at cnt=8 → credit_err=1 and sticky.
- Owner bubble: ch2 LOCKED, drops tvalid for 3 cycles while ch0 is valid → ch0 tready stays 0, ch2 resumes and finishes, then ch3/ch0 are arbitrated per rr_ptr=3.
- Reset mid-packet: rst_n low for 1 cycle during flit 2 of 4 → all outputs return to reset values, cnt=8, and the next arbitration starts at ch0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, injection FSM states, credit sizing helper.
package noc_pkg;

    localparam int unsigned FLIT_DATA_W = 64;
    localparam int unsigned FLIT_DEST_W = 6;

    typedef struct packed {
        logic [FLIT_DATA_W-1:0] data;
        logic [FLIT_DEST_W-1:0] dest;
        logic                   is_tail;
    } flit_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } inject_state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_inject_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned base;
    int unsigned c;

    // First requester at or after ptr wins; gnt stays zero when nobody requests.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        base  = {{(32-IDX_W){1'b0}}, ptr};
        for (int unsigned i = 0; i < N; i++) begin
            c = (base + i) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/axis_inject_mux.sv
// axis_inject_mux: packet-atomic round-robin injection of NUM_CHANNELS AXIS sources
// into one credit-flow-controlled router port with a registered flit output.
// Optional AXIS_INJECT_STATS_EN adds per-channel packet counts and a stall counter.
module axis_inject_mux
    import noc_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned TDATA_WIDTH       = 64,
    parameter int unsigned TID_WIDTH         = 2,
    parameter int unsigned TDEST_WIDTH       = 4,
    parameter int unsigned DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                                     clk_noc,
    input  logic                                     rst_n,
    input  logic [NUM_CHANNELS-1:0]                  axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                  axis_in_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_CHANNELS-1:0]                  axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   axis_in_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] axis_in_tdest,
    output logic [TDATA_WIDTH-1:0]                   data_out,
    output logic [DEST_WIDTH-1:0]                    dest_out,
    output logic                                     is_tail_out,
    output logic                                     send_out,
    input  logic                                     credit_in,
    output logic                                     credit_err
`ifdef AXIS_INJECT_STATS_EN
    ,
    output logic [NUM_CHANNELS-1:0][31:0]            pkt_count,
    output logic [31:0]                              stall_cycles
`endif
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    inject_state_t           state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        pick_idx, sel;
    logic [NUM_CHANNELS-1:0] pick_gnt;
    logic [CREDIT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    has_credit, xfer, sat_hit;

    rr_arbiter #(
        .N     (NUM_CHANNELS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (axis_in_tvalid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Ready steering: the owner while locked, otherwise the fresh round-robin pick.
    always_comb begin
        axis_in_tready = '0;
        sel            = (state_q == LOCKED) ? owner_q : pick_idx;
        has_credit     = (cnt_q != '0);
        if (rst_n && has_credit) begin
            if (state_q == LOCKED) axis_in_tready[owner_q] = 1'b1;
            else                   axis_in_tready = pick_gnt;
        end
        xfer = |(axis_in_tready & axis_in_tvalid);
    end

    // Next-state: lock on a non-tail beat, release and advance the pointer on a tail.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (axis_in_tlast[sel]) begin
                state_d  = IDLE;
                rr_ptr_d = (sel == IDX_W'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    // Credit arithmetic; a credit arriving on a full counter is flagged, not counted.
    always_comb begin
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        if (credit_in && !xfer) begin
            if (cnt_q == CREDIT_WIDTH'(FLIT_BUFFER_DEPTH)) sat_hit = 1'b1;
            else                                           cnt_d   = cnt_q + 1'b1;
        end else if (xfer && !credit_in) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
            credit_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            credit_err <= credit_err | sat_hit;
        end
    end

    // Registered flit output; fields hold when nothing is sent.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            is_tail_out <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
        end else begin
            send_out <= xfer;
            if (xfer) begin
                data_out    <= axis_in_tdata[sel];
                dest_out    <= {axis_in_tid[sel], axis_in_tdest[sel]};
                is_tail_out <= axis_in_tlast[sel];
            end
        end
    end

`ifdef AXIS_INJECT_STATS_EN
    // Completed-packet and credit-stall statistics, free-running with wrap.
    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            pkt_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (xfer && axis_in_tlast[sel]) pkt_count[sel] <= pkt_count[sel] + 32'd1;
            if (!has_credit && (|axis_in_tvalid)) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_inject_mux.sv
// Directed self-checking bench for axis_inject_mux (default build, 4 channels, depth 8).
module tb_axis_inject_mux;

    logic clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;

    logic              rst_n;
    logic [3:0]        tvalid, tready, tlast;
    logic [3:0][63:0]  tdata;
    logic [3:0][1:0]   tid;
    logic [3:0][3:0]   tdest;
    logic [63:0]       data_out;
    logic [5:0]        dest_out;
    logic              is_tail_out, send_out, credit_in, credit_err;

    axis_inject_mux #(
        .NUM_CHANNELS      (4),
        .TDATA_WIDTH       (64),
        .TID_WIDTH         (2),
        .TDEST_WIDTH       (4),
        .FLIT_BUFFER_DEPTH (8)
    ) dut (
        .clk_noc        (clk_noc),
        .rst_n          (rst_n),
        .axis_in_tvalid (tvalid),
        .axis_in_tready (tready),
        .axis_in_tdata  (tdata),
        .axis_in_tlast  (tlast),
        .axis_in_tid    (tid),
        .axis_in_tdest  (tdest),
        .data_out       (data_out),
        .dest_out       (dest_out),
        .is_tail_out    (is_tail_out),
        .send_out       (send_out),
        .credit_in      (credit_in),
        .credit_err     (credit_err)
    );

    // Per-channel source state: beats remaining, beat index, packet length, data base, hold-off.
    int unsigned rem [4];
    int unsigned beat[4];
    int unsigned len [4];
    logic [63:0] base[4];
    logic        hold[4];

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int sends;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            tvalid[c] = (rem[c] != 0) && !hold[c];
            tlast[c]  = ((beat[c] % len[c]) == len[c] - 1);
            tdata[c]  = base[c] + 64'(beat[c]);
        end
    endtask

    task automatic tick();
        logic [3:0] hs;
        hs = tready & tvalid;
        @(posedge clk_noc);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hs[c]) begin
                beat[c]++;
                rem[c]--;
            end
        end
        drive();
        #1;
    endtask

    task automatic chk_flit(input string tag, input logic [63:0] d, input logic tail);
        chk({tag, "_send"}, 64'(send_out), 64'd1);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_tail"}, 64'(is_tail_out), 64'(tail));
    endtask

    logic [63:0] fair_exp[16] = '{64'h100, 64'h101, 64'h200, 64'h201, 64'h300, 64'h301, 64'h000, 64'h001,
                                  64'h102, 64'h103, 64'h202, 64'h203, 64'h302, 64'h303, 64'h002, 64'h003};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        credit_in = 1'b0;
        tid       = {2'd3, 2'd2, 2'd1, 2'd1};
        tdest     = {4'd10, 4'd9, 4'd6, 4'd5};
        for (int c = 0; c < 4; c++) begin
            rem[c] = 0; beat[c] = 0; len[c] = 1; base[c] = '0; hold[c] = 1'b0;
        end
        // ch0 offers a 3-flit packet while reset is held
        rem[0] = 3; len[0] = 3; base[0] = 64'hA0;
        drive();
        tick();
        tick();
        chk("rst_send", 64'(send_out), 64'd0);
        chk("rst_tail", 64'(is_tail_out), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_dest", 64'(dest_out), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_tready", 64'(tready), 64'd0);

        // Single-channel packet
        rst_n = 1'b1;
        drive();
        #1;
        chk("single_tready", 64'(tready), 64'h1);
        tick();
        chk_flit("single0", 64'hA0, 1'b0);
        chk("single0_dest", 64'(dest_out), 64'h15);
        tick();
        chk_flit("single1", 64'hA1, 1'b0);
        tick();
        chk_flit("single2", 64'hA2, 1'b1);
        chk("single2_dest", 64'(dest_out), 64'h15);
        tick();
        chk("single_idle_send", 64'(send_out), 64'd0);
        chk("single_idle_hold", data_out, 64'hA2);

        // Return the 3 credits (cnt back to 8, rr_ptr = 1)
        credit_in = 1'b1;
        tick(); tick(); tick();

        // Fairness: all channels with two 2-flit packets, credit returned every cycle
        for (int c = 0; c < 4; c++) begin
            rem[c] = 4; beat[c] = 0; len[c] = 2; base[c] = 64'(c) << 8;
        end
        drive();
        #1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk_flit($sformatf("fair%0d", k), fair_exp[k], 1'((k % 2) == 1));
        end
        credit_in = 1'b0;
        tick();
        chk("fair_end_send", 64'(send_out), 64'd0);
        chk("fair_no_err", 64'(credit_err), 64'd0);

        // Credit exhaustion: ch1 12-flit packet, no credits returned
        rem[1] = 12; beat[1] = 0; len[1] = 12; base[1] = 64'h100;
        drive();
        #1;
        sends = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (send_out) sends++;
        end
        chk("exhaust_count", 64'(sends), 64'd8);
        chk("exhaust_tready", 64'(tready), 64'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        drive();
        #1;
        chk("credit1_nosend", 64'(send_out), 64'd0);
        chk("credit1_tready", 64'(tready), 64'h2);
        tick();
        chk_flit("credit1_flit", 64'h108, 1'b0);
        chk("credit1_tready_off", 64'(tready), 64'd0);
        tick();
        chk("credit1_after", 64'(send_out), 64'd0);

        // cnt=1 with credit every cycle: stream continues
        credit_in = 1'b1;
        tick();
        chk("sim_tready", 64'(tready), 64'h2);
        tick();
        chk_flit("sim9", 64'h109, 1'b0);
        tick();
        chk_flit("sim10", 64'h10A, 1'b0);
        tick();
        chk_flit("sim11", 64'h10B, 1'b1);
        for (int k = 0; k < 7; k++) tick();
        chk("full_no_err", 64'(credit_err), 64'd0);
        tick();
        chk("overflow_err", 64'(credit_err), 64'd1);
        credit_in = 1'b0;
        tick(); tick();
        chk("overflow_sticky", 64'(credit_err), 64'd1);

        // Owner bubble: ch2 locked, drops valid while ch0 waits (rr_ptr = 2)
        rem[2] = 4; beat[2] = 0; len[2] = 4; base[2] = 64'h200;
        drive();
        #1;
        tick();
        chk_flit("bub0", 64'h200, 1'b0);
        chk("bub0_dest", 64'(dest_out), 64'h29);
        tick();
        chk_flit("bub1", 64'h201, 1'b0);
        hold[2] = 1'b1;
        rem[0] = 1; beat[0] = 0; len[0] = 1; base[0] = 64'hF0;
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bub_tready%0d", k), 64'(tready), 64'h4);
            tick();
            chk($sformatf("bub_send%0d", k), 64'(send_out), 64'd0);
        end
        hold[2] = 1'b0;
        rem[3] = 1; beat[3] = 0; len[3] = 1; base[3] = 64'h300;
        drive();
        #1;
        tick();
        chk_flit("bub2", 64'h202, 1'b0);
        tick();
        chk_flit("bub3", 64'h203, 1'b1);
        tick();
        chk_flit("bub_ch3", 64'h300, 1'b1);
        chk("bub_ch3_dest", 64'(dest_out), 64'h3A);
        tick();
        chk_flit("bub_ch0", 64'hF0, 1'b1);
        chk("bub_ch0_dest", 64'(dest_out), 64'h15);
        tick();
        chk("bub_end", 64'(send_out), 64'd0);

        // Refill 6 credits, then reset in the middle of a ch1 packet (rr_ptr = 1)
        credit_in = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        credit_in = 1'b0;
        rem[1] = 4; beat[1] = 0; len[1] = 4; base[1] = 64'h100;
        drive();
        #1;
        tick();
        tick();
        chk_flit("mid1", 64'h101, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tready", 64'(tready), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) hold[c] = 1'b1;
        drive();
        #1;
        chk("mid_rst_send", 64'(send_out), 64'd0);
        chk("mid_rst_data", data_out, 64'd0);
        chk("mid_rst_dest", 64'(dest_out), 64'd0);
        chk("mid_rst_tail", 64'(is_tail_out), 64'd0);
        chk("mid_rst_err", 64'(credit_err), 64'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("mid_rst_cnt_full", 64'(credit_err), 64'd1);
        for (int c = 0; c < 4; c++) hold[c] = 1'b0;
        rem[0] = 1; beat[0] = 0; len[0] = 1; base[0] = 64'hF1;
        rem[3] = 1; beat[3] = 0; len[3] = 1; base[3] = 64'h301;
        drive();
        #1;
        chk("post_rst_pick", 64'(tready), 64'h1);
        tick();
        chk_flit("post0", 64'hF1, 1'b1);
        tick();
        chk_flit("post1", 64'h102, 1'b0);
        tick();
        chk_flit("post2", 64'h103, 1'b1);
        tick();
        chk_flit("post3", 64'h301, 1'b1);
        tick();
        chk("post_end", 64'(send_out), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
